// File: rtl/ppm_word_transmitter.sv
// PPM line coder: serialises each accepted word MSB-first into N-bit symbols,
// each sent as one L-clock pulse among 2^N slots, preceded by preamble symbols.
module ppm_word_transmitter #(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned N        = 2,
  parameter int unsigned L        = 2,
  parameter int unsigned PRE_SYMS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              pulse_out,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned SLOTS   = 1 << N;
  localparam int unsigned NSYM    = WORD_W / N;
  localparam int unsigned MAX_SYM = (PRE_SYMS > NSYM) ? PRE_SYMS : NSYM;
  localparam int unsigned CLK_W   = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned SLOT_W  = N;
  localparam int unsigned SYM_W   = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1;

  if (WORD_W % N != 0) begin : g_bad_word_w
    $error("ppm_word_transmitter: WORD_W must be a multiple of N");
  end
  if (L < 1) begin : g_bad_l
    $error("ppm_word_transmitter: L must be at least 1");
  end
  if (PRE_SYMS < 1) begin : g_bad_pre
    $error("ppm_word_transmitter: PRE_SYMS must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state;
  logic [CLK_W-1:0]    clk_ct;
  logic [SLOT_W-1:0]   slot_ct;
  logic [SYM_W-1:0]    sym_ct;
  logic [WORD_W-1:0]   shreg;

  logic              clk_last;
  logic              slot_last;
  logic              sym_end;
  logic              pre_last;
  logic              data_last;
  logic [N-1:0]      sym_val;

  assign clk_last  = (clk_ct == CLK_W'(L - 1));
  assign slot_last = (slot_ct == SLOT_W'(SLOTS - 1));
  assign sym_end   = clk_last && slot_last;
  assign pre_last  = (sym_ct == SYM_W'(PRE_SYMS - 1));
  assign data_last = (sym_ct == SYM_W'(NSYM - 1));
  assign sym_val   = shreg[WORD_W-1 -: N];

  // Symbol timing: clk_ct -> slot_ct -> sym_ct, with the word shifted at each data-symbol boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_ct  <= '0;
      slot_ct <= '0;
      sym_ct  <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          clk_ct  <= '0;
          slot_ct <= '0;
          sym_ct  <= '0;
          if (data_valid) begin
            shreg <= data_in;
            state <= PRE;
          end
        end
        PRE, DATA: begin
          if (clk_last) begin
            clk_ct <= '0;
            if (slot_last) begin
              slot_ct <= '0;
            end else begin
              slot_ct <= slot_ct + SLOT_W'(1);
            end
          end else begin
            clk_ct <= clk_ct + CLK_W'(1);
          end
          if (sym_end) begin
            if (state == PRE) begin
              if (pre_last) begin
                state  <= DATA;
                sym_ct <= '0;
              end else begin
                sym_ct <= sym_ct + SYM_W'(1);
              end
            end else begin
              shreg <= shreg << N;
              if (data_last) begin
                state  <= IDLE;
                sym_ct <= '0;
              end else begin
                sym_ct <= sym_ct + SYM_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Preamble marks the first and last slot, a pattern no single data symbol can make.
  assign pulse_out  = ((state == PRE)  && ((slot_ct == '0) || slot_last)) ||
                      ((state == DATA) && (slot_ct == sym_val));
  assign busy       = !rst && (state != IDLE);
  assign word_done  = !rst && (state == DATA) && data_last && sym_end;
  assign data_ready = !rst && (state == IDLE);

endmodule

// File: tb/tb_ppm_word_transmitter.sv
// Scoreboarded bench for ppm_word_transmitter: default instance plus a wide-symbol instance.
module tb_ppm_word_transmitter;

  typedef struct packed {
    logic pulse;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, valid_a, ready_a, pulse_a, busy_a, done_a;
  logic [7:0]  data_a;
  logic        rst_b, valid_b, ready_b, pulse_b, busy_b, done_b;
  logic [15:0] data_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  ppm_word_transmitter dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .data_in    (data_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .pulse_out  (pulse_a),
    .busy       (busy_a),
    .word_done  (done_a)
  );

  ppm_word_transmitter #(.WORD_W(16), .N(4), .L(3), .PRE_SYMS(2)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .data_in    (data_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .pulse_out  (pulse_b),
    .busy       (busy_b),
    .word_done  (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic exp_t mk(input bit p, input bit b, input bit d, input bit r);
    exp_t e;
    e.pulse = p; e.busy = b; e.done = d; e.ready = r;
    return e;
  endfunction

  task automatic push_e(input bit sel, input exp_t e);
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Expected per-cycle outputs of one word from cycle 0; ncyc > 0 truncates it.
  task automatic push_word(input bit sel, input logic [31:0] d, input int ncyc);
    int ww, n, l, pre, slots, t, lim, sym, slot, v;
    bit p;
    if (sel) begin ww = 16; n = 4; l = 3; pre = 2; end
    else     begin ww = 8;  n = 2; l = 2; pre = 1; end
    slots = 1 << n;
    t     = (pre + ww / n) * slots * l;
    lim   = (ncyc > 0 && ncyc < t) ? ncyc : t;
    for (int c = 0; c < lim; c++) begin
      sym  = c / (slots * l);
      slot = (c / l) % slots;
      if (sym < pre) begin
        p = (slot == 0) || (slot == slots - 1);
      end else begin
        v = int'((d >> (ww - n * (sym - pre + 1))) & ((32'd1 << n) - 32'd1));
        p = (slot == v);
      end
      push_e(sel, mk(p, 1'b1, c == t - 1, 1'b0));
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check($sformatf("a_pulse@%0d", cyc), 32'(pulse_a), 32'(e.pulse));
      check($sformatf("a_busy@%0d",  cyc), 32'(busy_a),  32'(e.busy));
      check($sformatf("a_done@%0d",  cyc), 32'(done_a),  32'(e.done));
      check($sformatf("a_ready@%0d", cyc), 32'(ready_a), 32'(e.ready));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check($sformatf("b_pulse@%0d", cyc), 32'(pulse_b), 32'(e.pulse));
      check($sformatf("b_busy@%0d",  cyc), 32'(busy_b),  32'(e.busy));
      check($sformatf("b_done@%0d",  cyc), 32'(done_b),  32'(e.done));
      check($sformatf("b_ready@%0d", cyc), 32'(ready_b), 32'(e.ready));
    end
    cyc++;
  endtask

  task automatic drain();
    while (qa.size() > 0 || qb.size() > 0) tick();
  endtask

  // One idle cycle, a single-cycle valid, the whole word, then the following idle cycle.
  task automatic send(input bit sel, input logic [31:0] d);
    push_e(sel, mk(1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    push_word(sel, d, 0);
    if (sel) begin valid_b = 1'b1; data_b = d[15:0]; end
    else     begin valid_a = 1'b1; data_a = d[7:0];  end
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    drain();
    push_e(sel, mk(1'b0, 1'b0, 1'b0, 1'b1));
    tick();
  endtask

  initial begin
    rst_a = 1'b1; valid_a = 1'b1; data_a = 8'hB4;
    rst_b = 1'b1; valid_b = 1'b1; data_b = 16'hA5C3;

    // Reset held with valid high: everything quiet, nothing accepted.
    repeat (3) begin
      push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
      push_e(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
    end
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) begin
      push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
      push_e(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1));
    end
    repeat (3) tick();

    send(1'b0, 32'hB4);
    send(1'b0, 32'hFF);
    send(1'b0, 32'h00);

    // Back-to-back with valid held; data changes mid-word must not disturb the first word.
    push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    push_word(1'b0, 32'hB4, 0);
    push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
    push_word(1'b0, 32'h12, 0);
    valid_a = 1'b1; data_a = 8'hB4;
    tick();
    data_a = 8'h12;
    repeat (40) tick();
    tick();
    valid_a = 1'b0;
    drain();

    // Reset at cycle 20 of a word: abandoned without word_done, then a clean new word.
    push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    push_word(1'b0, 32'hB4, 21);
    valid_a = 1'b1; data_a = 8'hB4;
    tick();
    valid_a = 1'b0;
    repeat (20) tick();
    rst_a = 1'b1;
    push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    rst_a = 1'b0;
    push_e(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    send(1'b0, 32'h1B);

    // Wide-symbol instance: T = 288.
    send(1'b1, 32'hA5C3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
